// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-period waveform whose high time follows a shadowed width command.
// Optional build macro SERVO_PWM_CLAMP_EN clamps the latched width to [MIN_PULSE, MAX_PULSE].
module servo_pwm_gen #(
    parameter int PERIOD    = 2_000_000,
    parameter int MIN_PULSE = 50_000,
    parameter int MAX_PULSE = 250_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [20:0] pulse_width,
    output logic        pwm_out,
    output logic        done_period,
    output logic        busy
);

    localparam logic [20:0] LAST_CNT = 21'(PERIOD - 1);
    localparam logic [20:0] MIN_W    = 21'(MIN_PULSE);
    localparam logic [20:0] MAX_W    = 21'(MAX_PULSE);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic [20:0] cnt_r;
    logic [20:0] shadow_r;
    logic        pwm_r;
    logic        done_r;
    logic        busy_r;

    function automatic logic [20:0] sat(input logic [20:0] x);
        logic [20:0] y;
`ifdef SERVO_PWM_CLAMP_EN
        if (x < MIN_W) begin
            y = MIN_W;
        end else if (x > MAX_W) begin
            y = MAX_W;
        end else begin
            y = x;
        end
`else
        // Identity in this build; the bounds are folded in so they stay referenced.
        y = (MIN_W > MAX_W) ? x : x;
`endif
        return y;
    endfunction

    // Period counter, shadow width and registered outputs; disable beats a boundary strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            cnt_r    <= 21'd0;
            shadow_r <= 21'd0;
            pwm_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pwm_r  <= 1'b0;
                    done_r <= 1'b0;
                    cnt_r  <= 21'd0;
                    if (enable) begin
                        state_r  <= RUN;
                        shadow_r <= sat(pulse_width);
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_r <= IDLE;
                        cnt_r   <= 21'd0;
                        pwm_r   <= 1'b0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        pwm_r  <= (cnt_r < shadow_r);
                        busy_r <= 1'b1;
                        if (cnt_r == LAST_CNT) begin
                            cnt_r    <= 21'd0;
                            shadow_r <= sat(pulse_width);
                            done_r   <= 1'b1;
                        end else begin
                            cnt_r    <= cnt_r + 21'd1;
                            done_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 21'd0;
                    pwm_r   <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign pwm_out     = pwm_r;
    assign done_period = done_r;
    assign busy        = busy_r;

endmodule
